// File: rtl/conv_layer_output_cache_pkg.sv
// Shared constants and read-FSM encoding for the conv layer output row cache.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package conv_layer_output_cache_pkg;
  localparam int OUT_SIZE = 6;
  localparam int OUT_ROWS = 6;
  localparam int DW = `DATA_WIDTH;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(OUT_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(OUT_ROWS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } rd_state_e;
endpackage

// File: rtl/conv_output_bank.sv
// One row-wide storage bank: parallel write, full flag, word-select read (word 0 in the MSBs).
module conv_output_bank
  import conv_layer_output_cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   clr,
  input  logic [OUT_SIZE*DW-1:0] data_in,
  input  logic [IDX_W-1:0]       sel,
  output logic                   full,
  output logic [DW-1:0]          word
);
  logic [OUT_SIZE*DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      mem  <= data_in;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < OUT_SIZE; i++) begin
      if (sel == IDX_W'(i)) word = mem[(OUT_SIZE-1-i)*DW +: DW];
    end
  end

`ifdef DEBUG
  logic [DW-1:0] dbg_word [OUT_SIZE];
  always_comb begin
    for (int i = 0; i < OUT_SIZE; i++) dbg_word[i] = mem[(OUT_SIZE-1-i)*DW +: DW];
  end
`endif
endmodule

// File: rtl/conv_layer_output_cache.sv
// Double-banked output row cache: captures a parallel row, streams it word by word.
//   state   | meaning
//   S_IDLE  | no row to drain, data_out_valid=0
//   S_DRAIN | presenting bank[rd_ptr] word col_index with data_out_valid=1
module conv_layer_output_cache
  import conv_layer_output_cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   row_valid,
  input  logic [OUT_SIZE*DW-1:0] data_in_bus,
  output logic                   row_ready,
  output logic [DW-1:0]          data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic [IDX_W-1:0]       col_index,
  output logic [IDX_W-1:0]       row_index,
  output logic                   frame_done,
  output logic                   overflow
);
  rd_state_e     state, state_nxt;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    full, wr_en, clr;
  logic [DW-1:0] bank_word [2];
  logic          wr_fire, accept, last_accept;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    conv_output_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[b]),
      .clr     (clr[b]),
      .data_in (data_in_bus),
      .sel     (col_index),
      .full    (full[b]),
      .word    (bank_word[b])
    );
  end

  assign row_ready      = !(full[0] && full[1]);
  assign wr_fire        = row_valid && row_ready;
  assign data_out_valid = (state == S_DRAIN);
  assign accept         = data_out_valid && data_out_ready;
  assign last_accept    = accept && (col_index == LAST_COL);
  assign data_out       = data_out_valid ? bank_word[rd_ptr] : '0;
  assign frame_done     = last_accept && (row_index == LAST_ROW) && !rst;

  always_comb begin
    wr_en = '0;
    clr   = '0;
    wr_en[wr_ptr] = wr_fire;
    clr[rd_ptr]   = last_accept;
  end

  // Look at a same-cycle capture too, so a fresh row shows up one cycle after its strobe
  // and a row landing in the other bank during the last accept follows with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (full[rd_ptr] || (wr_fire && (wr_ptr == rd_ptr))) state_nxt = S_DRAIN;
      S_DRAIN:
        if (last_accept && !(full[~rd_ptr] || (wr_fire && (wr_ptr != rd_ptr))))
          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      col_index <= '0;
      row_index <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_fire) wr_ptr <= ~wr_ptr;
      if (row_valid && !row_ready) overflow <= 1'b1;
      if (accept) begin
        if (col_index == LAST_COL) begin
          col_index <= '0;
          rd_ptr    <= ~rd_ptr;
          row_index <= (row_index == LAST_ROW) ? '0 : row_index + IDX_W'(1);
        end else begin
          col_index <= col_index + IDX_W'(1);
        end
      end
    end
  end
endmodule
